seq_detect_prog: RTL and testbench

Programmable serial sequence detector: the parametrised successor of the team's fixed-pattern 5-state detectors. It recognises a run-time-loaded WIDTH-bit pattern on a qualified serial input, in either overlapping or non-overlapping mode. It emits a registered one-cycle match pulse and keeps a saturating match count. It sits behind the serial front-end, sampling one bit per clock when `x_valid` is high.

---
 rtl/seq_detect_prog.sv | 131 +++++++++++++
 tb/tb_seq_detect_prog.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//   Programmable serial sequence detector. A WIDTH-bit pattern is loaded at run
//   time. The detector then watches a qualified serial stream and pulses y_out
//   for one cycle on every match. Matches may overlap or not, as selected by
//   the overlap input. It also keeps a saturating count of matches.
//
// Ports
//   clock      : rising-edge clock
//   reset      : synchronous, active-low reset
//   x_in       : serial data bit
//   x_valid    : x_in is sampled only when high
//   pat_load   : load pat_in as the new pattern and restart detection
//   pat_in     : pattern; bit WIDTH-1 is the first bit expected on the line
//   overlap    : 1 = overlapping matches, 0 = non-overlapping
//   y_out      : registered one-cycle match pulse
//   armed      : high while the window is full and comparing
//   match_cnt  : saturating match count since reset or the last pat_load
//   cnt_sat    : high once match_cnt has reached all-ones
// -----------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic             x_valid,
  input  logic             pat_load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             overlap,
  output logic             y_out,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pattern;
  logic [WIDTH-2:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic             r_y;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  logic [WIDTH-1:0] w_win;
  logic [FW-1:0]    w_fill_n;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_next;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Candidate window: stored history followed by the bit arriving now.
  assign w_win      = {r_hist, x_in};
  // The fill count tops out at WIDTH once the window has been filled.
  assign w_fill_n   = (r_fill >= FILL_FULL) ? FILL_FULL : r_fill + FW'(1);
  assign w_match    = (w_fill_n == FILL_FULL) && (w_win == r_pattern);
  assign w_cnt_next = sat_inc(r_cnt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_y       <= 1'b0;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
    end else begin
      // y_out is a pulse: it is cleared on every edge unless a match sets it.
      r_y <= 1'b0;
      if (pat_load) begin
        // A valid bit arriving with the load is deliberately dropped.
        r_pattern <= pat_in;
        r_hist    <= '0;
        r_fill    <= '0;
        r_cnt     <= '0;
        r_sat     <= 1'b0;
        r_state   <= S_FILL;
        r_armed   <= 1'b0;
      end else if (x_valid && (r_state != S_IDLE)) begin
        r_hist <= w_win[WIDTH-2:0];
        if (w_match) begin
          r_y   <= 1'b1;
          r_cnt <= w_cnt_next;
          r_sat <= &w_cnt_next;
          if (overlap) begin
            // The window stays full, so the very next bit can match again.
            r_fill  <= FILL_FULL;
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end else begin
            // Refill from scratch: WIDTH fresh bits before the next match.
            r_fill  <= '0;
            r_state <= S_FILL;
            r_armed <= 1'b0;
          end
        end else begin
          r_fill <= w_fill_n;
          if (w_fill_n == FILL_FULL) begin
            r_state <= S_ARMED;
            r_armed <= 1'b1;
          end else begin
            r_state <= S_FILL;
            r_armed <= 1'b0;
          end
        end
      end
    end
  end

  assign y_out     = r_y;
  assign armed     = r_armed;
  assign match_cnt = r_cnt;
  assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  localparam int WIDTH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             x_in = 1'b0;
  logic             x_valid = 1'b0;
  logic             pat_load = 1'b0;
  logic [WIDTH-1:0] pat_in = '0;
  logic             overlap = 1'b0;

  logic       y_out, armed, cnt_sat;
  logic [7:0] match_cnt;
  logic       s_y_out, s_armed, s_cnt_sat;
  logic [1:0] s_match_cnt;

  seq_detect_prog #(.WIDTH(WIDTH), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .y_out(y_out), .armed(armed), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  // Narrow-counter instance on the same stimulus, used for saturation checks.
  seq_detect_prog #(.WIDTH(WIDTH), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
    .pat_load(pat_load), .pat_in(pat_in), .overlap(overlap),
    .y_out(s_y_out), .armed(s_armed), .match_cnt(s_match_cnt), .cnt_sat(s_cnt_sat)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       y;
    logic       armed;
    logic [7:0] cnt;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Apply one cycle of inputs, then sample just after the active edge.
  task automatic tick(input logic rst_n, input logic ld, input logic xv, input logic xi);
    reset    = rst_n;
    pat_load = ld;
    x_valid  = xv;
    x_in     = xi;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic y, input logic a, input int c, input logic s);
    exp_t e;
    e.y = y; e.armed = a; e.cnt = 8'(c); e.sat = s;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    exp_t e;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({y_out, armed, match_cnt, cnt_sat} !== {e.y, e.armed, e.cnt, e.sat}) begin
      n_err++;
      $display("FAIL reset_state: got y/armed/cnt/sat=%b/%b/%0d/%b want %b/%b/%0d/%b",
               y_out, armed, match_cnt, cnt_sat, e.y, e.armed, e.cnt, e.sat);
    end
    // IDLE ignores valid data entirely.
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 1'b0, 0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      e = sb.pop_front();
      n_cmp++;
      if ({y_out, armed, match_cnt, cnt_sat} !== {e.y, e.armed, e.cnt, e.sat}) begin
        n_err++;
        $display("FAIL idle_ignore[%0d]: got y/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                 i, y_out, armed, match_cnt, e.y, e.armed, e.cnt);
      end
    end
  endtask

  // Loads a pattern and checks the cleared state right after the load edge.
  task automatic test_stream(input string name, input logic [3:0] pat, input logic ovl,
                             input logic [15:0] bits, input logic [15:0] yexp,
                             input logic [15:0] aexp, input int n, input int cnt_e[16]);
    exp_t e;
    pat_in  = pat;
    overlap = ovl;
    push(1'b0, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if ({y_out, armed, match_cnt} !== {e.y, e.armed, e.cnt}) begin
      n_err++;
      $display("FAIL %s_load: got y/armed/cnt=%b/%b/%0d want %b/%b/%0d",
               name, y_out, armed, match_cnt, e.y, e.armed, e.cnt);
    end
    for (int i = 0; i < n; i++) begin
      push(yexp[n-1-i], aexp[n-1-i], cnt_e[i], 1'b0);
      tick(1'b1, 1'b0, 1'b1, bits[n-1-i]);
      e = sb.pop_front();
      n_cmp++;
      if ({y_out, armed, match_cnt, cnt_sat} !== {e.y, e.armed, e.cnt, e.sat}) begin
        n_err++;
        $display("FAIL %s_bit%0d: got y/armed/cnt/sat=%b/%b/%0d/%b want %b/%b/%0d/%b",
                 name, i + 1, y_out, armed, match_cnt, cnt_sat, e.y, e.armed, e.cnt, e.sat);
      end
    end
  endtask

  task automatic test_overlap_1011;
    int c[16] = '{0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_stream("ovl1011", 4'b1011, 1'b1, 16'b1011011, 16'b0001001, 16'b0001111, 7, c);
  endtask

  task automatic test_nonoverlap_1011;
    int c[16] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_stream("novl1011", 4'b1011, 1'b0, 16'b1011011, 16'b0001000, 16'b0000000, 7, c);
  endtask

  task automatic test_back_to_back;
    int c1[16] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int c0[16] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_stream("ones_ovl", 4'b1111, 1'b1, 16'b111111, 16'b000111, 16'b000111, 6, c1);
    test_stream("ones_novl", 4'b1111, 1'b0, 16'b111111, 16'b000100, 16'b000000, 6, c0);
  endtask

  task automatic test_gapped;
    exp_t       e;
    logic [6:0] bits = 7'b1011011;
    logic [6:0] yv   = 7'b0001001;
    logic [6:0] av   = 7'b0001111;
    int         c[7] = '{0, 0, 0, 1, 1, 1, 2};
    logic [3:0] tail = 4'b0111;
    logic [3:0] tarm = 4'b0001;
    pat_in  = 4'b1011;
    overlap = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      push(yv[6-i], av[6-i], c[i], 1'b0);
      tick(1'b1, 1'b0, 1'b1, bits[6-i]);
      e = sb.pop_front();
      n_cmp++;
      if ({y_out, armed, match_cnt} !== {e.y, e.armed, e.cnt}) begin
        n_err++;
        $display("FAIL gap_valid%0d: got y/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                 i + 1, y_out, armed, match_cnt, e.y, e.armed, e.cnt);
      end
      // Invalid cycle: the pulse drops, everything else holds.
      push(1'b0, av[6-i], c[i], 1'b0);
      tick(1'b1, 1'b0, 1'b0, ~bits[6-i]);
      e = sb.pop_front();
      n_cmp++;
      if ({y_out, armed, match_cnt} !== {e.y, e.armed, e.cnt}) begin
        n_err++;
        $display("FAIL gap_idle%0d: got y/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                 i + 1, y_out, armed, match_cnt, e.y, e.armed, e.cnt);
      end
    end
    // Load with a valid 1: that bit must be dropped and the count cleared.
    push(1'b0, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({y_out, armed, match_cnt} !== {e.y, e.armed, e.cnt}) begin
      n_err++;
      $display("FAIL coincident_load: got y/armed/cnt=%b/%b/%0d want %b/%b/%0d",
               y_out, armed, match_cnt, e.y, e.armed, e.cnt);
    end
    for (int i = 0; i < 4; i++) begin
      push(1'b0, tarm[3-i], 0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, tail[3-i]);
      e = sb.pop_front();
      n_cmp++;
      if ({y_out, armed, match_cnt} !== {e.y, e.armed, e.cnt}) begin
        n_err++;
        $display("FAIL dropped_bit%0d: got y/armed/cnt=%b/%b/%0d want %b/%b/%0d",
                 i + 1, y_out, armed, match_cnt, e.y, e.armed, e.cnt);
      end
    end
  endtask

  task automatic test_saturation;
    exp_t e;
    int   m;
    pat_in  = 4'b1111;
    overlap = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      m = (k >= 4) ? k - 3 : 0;
      push(k >= 4, k >= 4, (m > 3) ? 3 : m, m >= 3);
      tick(1'b1, 1'b0, 1'b1, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({s_y_out, s_armed, 6'b0, s_match_cnt, s_cnt_sat} !== {e.y, e.armed, e.cnt, e.sat}) begin
        n_err++;
        $display("FAIL sat_bit%0d: got y/armed/cnt/sat=%b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, s_y_out, s_armed, s_match_cnt, s_cnt_sat, e.y, e.armed, e.cnt, e.sat);
      end
    end
    n_cmp++;
    if (match_cnt !== 8'd8) begin
      n_err++;
      $display("FAIL wide_cnt: got %0d want 8", match_cnt);
    end
    // Reset mid-stream while another match pulse would have been due.
    push(1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if ({s_y_out, s_armed, s_match_cnt, s_cnt_sat, y_out, armed, match_cnt, cnt_sat} !==
        {e.y, e.armed, e.cnt[1:0], e.sat, e.y, e.armed, e.cnt, e.sat}) begin
      n_err++;
      $display("FAIL midstream_reset: got y/armed/cnt/sat=%b/%b/%0d/%b narrow=%b/%b/%0d/%b want all 0",
               y_out, armed, match_cnt, cnt_sat, s_y_out, s_armed, s_match_cnt, s_cnt_sat);
    end
  endtask

  task automatic test_reset_with_load;
    exp_t e;
    pat_in  = 4'b1111;
    overlap = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    // Reset wins over a coincident load: the detector must stay in IDLE.
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 1'b0, 0, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 1'b1);
      e = sb.pop_front();
      n_cmp++;
      if ({y_out, armed, match_cnt, cnt_sat} !== {e.y, e.armed, e.cnt, e.sat}) begin
        n_err++;
        $display("FAIL reset_beats_load%0d: got y/armed/cnt/sat=%b/%b/%0d/%b want 0/0/0/0",
                 i + 1, y_out, armed, match_cnt, cnt_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_1011();
    test_nonoverlap_1011();
    test_back_to_back();
    test_gapped();
    test_saturation();
    test_reset_with_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
